// File: rtl/reg_file.sv
// Register file for the 16-bit MIPS datapath: one write port, two combinational
// read ports, register 0 hard-wired to zero, write-to-read bypass.

// One read port: zero for index 0 or during reset, bypass on a matching write.
module reg_file_rdport #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [ADDR_W-1:0]                waddr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic [ADDR_W-1:0]                raddr,
    output logic [DATA_W-1:0]                rdata
);

    // Priority: reset/R0 force zero, then bypass, then stored value.
    always_comb begin
        rdata = regs[raddr];
        if (!rst_n || raddr == '0)
            rdata = '0;
        else if (we && waddr == raddr)
            rdata = wdata;
    end

endmodule

module reg_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREG  = 2**ADDR_W;
    localparam int NPORT = 2;

    // Only entries 1..NREG-1 are storage; entry 0 is a constant zero.
    logic [NREG-1:1][DATA_W-1:0] mem;
    logic [NREG-1:0][DATA_W-1:0] regs;

    logic [NPORT-1:0][ADDR_W-1:0] raddr;
    logic [NPORT-1:0][DATA_W-1:0] rdata;

    assign regs  = {mem, {DATA_W{1'b0}}};
    assign raddr = {raddr2, raddr1};
    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

    // Write port: async clear, single write per edge, writes to index 0 dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we && waddr != '0) begin
            for (int i = 1; i < NREG; i++)
                if (waddr == ADDR_W'(i))
                    mem[i] <= wdata;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_rd
            reg_file_rdport #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_rd (
                .regs  (regs),
                .rst_n (rst_n),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .raddr (raddr[p]),
                .rdata (rdata[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, R0, bypass, we=0, fill/readback, async reset.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic [15:0] rdata1;
    logic [15:0] rdata2;

    int checks = 0;
    int errors = 0;

    reg_file #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write one register on the next rising edge, inputs changed on the falling edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    initial begin
        logic [15:0] e;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 3'd1; raddr2 = 3'd2;
        #12;
        chk("reset_rd1", rdata1, 16'h0000);
        chk("reset_rd2", rdata2, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        // Fill regs 1..7 with i*0x1111 and sweep both ports
        for (int i = 1; i < 8; i++) begin
            e = 16'(i * 16'h1111);
            wr(3'(i), e);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i); raddr2 = 3'(7 - i); #1;
            chk("fill_rd1", rdata1, 16'(i * 16'h1111));
            chk("fill_rd2", rdata2, 16'((7 - i) * 16'h1111));
        end

        // Reset asserted between edges: everything reads 0 at once
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i); #1;
            chk("rst_clear", rdata1, 16'h0000);
        end
        @(negedge clk); rst_n = 1'b1;
        wr(3'd3, 16'hBEEF);
        raddr1 = 3'd3; #1;
        chk("post_rst_wr", rdata1, 16'hBEEF);

        // R0 write is dropped and always reads 0
        @(negedge clk);
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0; raddr2 = 3'd0; #1;
        chk("r0_pre_rd1", rdata1, 16'h0000);
        chk("r0_pre_rd2", rdata2, 16'h0000);
        @(posedge clk); #1;
        we = 1'b0; #1;
        chk("r0_post_rd1", rdata1, 16'h0000);
        chk("r0_post_rd2", rdata2, 16'h0000);

        // Bypass on both ports
        wr(3'd5, 16'h1111);
        @(negedge clk);
        we = 1'b1; waddr = 3'd5; wdata = 16'h2222; raddr1 = 3'd5; raddr2 = 3'd5; #1;
        chk("byp_pre_rd1", rdata1, 16'h2222);
        chk("byp_pre_rd2", rdata2, 16'h2222);
        @(posedge clk); #1;
        we = 1'b0; #1;
        chk("byp_post_rd1", rdata1, 16'h2222);
        chk("byp_post_rd2", rdata2, 16'h2222);

        // No bypass or write with we=0
        wr(3'd6, 16'h00AA);
        @(negedge clk);
        we = 1'b0; waddr = 3'd6; wdata = 16'h5555; raddr2 = 3'd6; #1;
        chk("nowe_pre", rdata2, 16'h00AA);
        @(posedge clk); #1;
        chk("nowe_post", rdata2, 16'h00AA);

        // Async reset while a write is pending: output drops, edge does not write
        wr(3'd2, 16'h1234);
        @(negedge clk);
        we = 1'b1; waddr = 3'd2; wdata = 16'h4321; raddr1 = 3'd2; #1;
        chk("arst_byp", rdata1, 16'h4321);
        #1 rst_n = 1'b0; #1;
        chk("arst_zero", rdata1, 16'h0000);
        @(posedge clk); #1;
        chk("arst_edge", rdata1, 16'h0000);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1; #1;
        chk("arst_nowr", rdata1, 16'h0000);
        raddr2 = 3'd3; #1;
        chk("arst_r3", rdata2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
